// File: rtl/timer_sched.sv
// Round-robin arbiter that lends one shared N-bit one-shot countdown to R
// requesters and returns a one-cycle done pulse to the owner on expiry.
module timer_sched #(
    parameter int N = 3,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] load,
    output logic [R-1:0]   grant,
    output logic [R-1:0]   done,
    output logic           busy,
    output logic [N-1:0]   count
);

    localparam int PW = $clog2(R);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;

    logic          found;
    logic [PW-1:0] win;
    logic [N-1:0]  win_load;
    int            idx;

    // Search starts at ptr and wraps, so the most recent winner is considered last.
    // NOTE: every signal gets a default before the loop so no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < R; k++) begin
            idx = (int'(ptr) + k) % R;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        win_load = load[win*N +: N];
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            count <= '0;
        end else begin
            done <= '0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state <= RUN;
                        owner <= win;
                        grant <= R'(1) << win;
                        busy  <= 1'b1;
                        ptr   <= (win == PW'(R - 1)) ? '0 : win + 1'b1;
                        // A zero load behaves like one so the owner always gets a done.
                        count <= (win_load == '0) ? N'(1) : win_load;
                    end
                end
                RUN: begin
                    if (!req[owner]) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                    end else if (count == N'(1)) begin
                        state       <= IDLE;
                        grant       <= '0;
                        busy        <= 1'b0;
                        count       <= '0;
                        done[owner] <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_sched.sv
// Directed self-checking bench for timer_sched (N=3, R=4); outputs sampled
// 1ns after each rising edge against hand-computed values.
module tb_timer_sched;

    localparam int N = 3;
    localparam int R = 4;

    logic           clk;
    logic           rst;
    logic [R-1:0]   req;
    logic [R*N-1:0] load;
    logic [R-1:0]   grant;
    logic [R-1:0]   done;
    logic           busy;
    logic [N-1:0]   count;

    int errors = 0;
    int checks = 0;

    timer_sched #(.N(N), .R(R)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .load  (load),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input logic [R-1:0] g, input logic [R-1:0] d,
                             input logic b, input logic [N-1:0] c);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".done"},  32'(done),  32'(d));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".count"}, 32'(count), 32'(c));
    endtask

    task automatic set_load(input int i, input logic [N-1:0] v);
        load[i*N +: N] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b0;
        req  = '0;
        load = '0;

        // Reset state
        do_reset();
        check_all("reset", 4'b0000, 4'b0000, 1'b0, 3'd0);

        // Single requester, load 3
        set_load(0, 3'd3);
        req = 4'b0001;
        tick(); check_all("single.e0", 4'b0001, 4'b0000, 1'b1, 3'd3);
        tick(); check_all("single.e1", 4'b0001, 4'b0000, 1'b1, 3'd2);
        tick(); check_all("single.e2", 4'b0001, 4'b0000, 1'b1, 3'd1);
        tick(); check_all("single.e3", 4'b0000, 4'b0001, 1'b0, 3'd0);
        req = 4'b0000;
        tick(); check_all("single.idle", 4'b0000, 4'b0000, 1'b0, 3'd0);

        // Simultaneous requests after reset
        do_reset();
        set_load(0, 3'd2);
        set_load(1, 3'd1);
        req = 4'b0011;
        tick(); check_all("simul.g0", 4'b0001, 4'b0000, 1'b1, 3'd2);
        tick(); check_all("simul.c0", 4'b0001, 4'b0000, 1'b1, 3'd1);
        tick(); check_all("simul.d0", 4'b0000, 4'b0001, 1'b0, 3'd0);
        req = 4'b0010;
        tick(); check_all("simul.g1", 4'b0010, 4'b0000, 1'b1, 3'd1);
        tick(); check_all("simul.d1", 4'b0000, 4'b0010, 1'b0, 3'd0);
        req = 4'b0000;
        tick(); check_all("simul.idle", 4'b0000, 4'b0000, 1'b0, 3'd0);

        // Round-robin fairness; requester 1 re-requests while 2 runs
        do_reset();
        for (int i = 0; i < R; i++) set_load(i, 3'd1);
        req = 4'b1111;
        tick(); check_all("rr.g0", 4'b0001, 4'b0000, 1'b1, 3'd1);
        tick(); check_all("rr.d0", 4'b0000, 4'b0001, 1'b0, 3'd0);
        req = 4'b1110;
        tick(); check_all("rr.g1", 4'b0010, 4'b0000, 1'b1, 3'd1);
        tick(); check_all("rr.d1", 4'b0000, 4'b0010, 1'b0, 3'd0);
        req = 4'b1100;
        tick(); check_all("rr.g2", 4'b0100, 4'b0000, 1'b1, 3'd1);
        req = 4'b1110;
        tick(); check_all("rr.d2", 4'b0000, 4'b0100, 1'b0, 3'd0);
        req = 4'b1010;
        tick(); check_all("rr.g3", 4'b1000, 4'b0000, 1'b1, 3'd1);
        tick(); check_all("rr.d3", 4'b0000, 4'b1000, 1'b0, 3'd0);
        req = 4'b0010;
        tick(); check_all("rr.g1b", 4'b0010, 4'b0000, 1'b1, 3'd1);
        tick(); check_all("rr.d1b", 4'b0000, 4'b0010, 1'b0, 3'd0);
        req = 4'b0000;
        tick();

        // Abandonment mid-run (ptr is now 2)
        set_load(2, 3'd7);
        req = 4'b0100;
        tick(); check_all("abn.g2", 4'b0100, 4'b0000, 1'b1, 3'd7);
        tick(); check_all("abn.c6", 4'b0100, 4'b0000, 1'b1, 3'd6);
        tick(); check_all("abn.c5", 4'b0100, 4'b0000, 1'b1, 3'd5);
        tick(); check_all("abn.c4", 4'b0100, 4'b0000, 1'b1, 3'd4);
        req = 4'b0000;
        tick(); check_all("abn.drop", 4'b0000, 4'b0000, 1'b0, 3'd0);
        tick(); check_all("abn.nodone", 4'b0000, 4'b0000, 1'b0, 3'd0);

        // Load zero behaves like load one (ptr is now 3)
        set_load(3, 3'd0);
        req = 4'b1000;
        tick(); check_all("zero.g3", 4'b1000, 4'b0000, 1'b1, 3'd1);
        tick(); check_all("zero.d3", 4'b0000, 4'b1000, 1'b0, 3'd0);
        req = 4'b0000;
        tick();

        // Maximum load: done exactly 7 edges after grant; later load changes ignored
        set_load(0, 3'd7);
        req = 4'b0001;
        tick(); check_all("max.g0", 4'b0001, 4'b0000, 1'b1, 3'd7);
        set_load(0, 3'd2);
        for (int c = 6; c >= 1; c--) begin
            tick(); check_all("max.run", 4'b0001, 4'b0000, 1'b1, 3'(c));
        end
        tick(); check_all("max.done", 4'b0000, 4'b0001, 1'b0, 3'd0);
        req = 4'b0000;
        tick();

        // Reset during RUN, then pointer restarts at 0 (ptr was 1)
        set_load(1, 3'd4);
        set_load(0, 3'd3);
        req = 4'b0010;
        tick(); check_all("rrun.g1", 4'b0010, 4'b0000, 1'b1, 3'd4);
        rst = 1'b1;
        tick(); check_all("rrun.rst", 4'b0000, 4'b0000, 1'b0, 3'd0);
        rst = 1'b0;
        req = 4'b1001;
        tick(); check_all("rrun.g0", 4'b0001, 4'b0000, 1'b1, 3'd3);
        tick(); check_all("rrun.c2", 4'b0001, 4'b0000, 1'b1, 3'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
